l3_cache: RTL and testbench

Direct-mapped, write-through L3 cache serving the L2 cache's miss and write-through port. It accepts one L2 request at a time and holds `L3_stall` high until the request is complete. For reads it returns the full 128-byte line on `L2_block`. Misses are filled, and writes forwarded, through a simple request/ready port to main memory.

---
 rtl/l3_cache.sv | 166 ++++++++++++++++
 tb/tb_l3_cache.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/l3_cache.sv
// l3_cache: direct-mapped write-through L3 with 128-byte lines; define L3_WRITE_ALLOCATE_EN to fill on write misses
module l3_cache #(
    parameter int SETS_LOG2   = 8,
    parameter int HIT_LATENCY = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   L3_addr,
    input  logic [31:0]   L3_wdata,
    input  logic          L3_renable,
    input  logic          L3_wenable,
    output logic          L3_stall,
    output logic [0:1023] L2_block,
    output logic [31:0]   mem_addr,
    output logic          mem_renable,
    output logic          mem_wenable,
    output logic [31:0]   mem_wdata,
    input  logic [0:1023] mem_rdata,
    input  logic          mem_ready
);
    localparam int SETS  = 1 << SETS_LOG2;
    localparam int TAG_W = 25 - SETS_LOG2;
    localparam int CNT_W = $clog2(HIT_LATENCY + 1) + 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, DONE, WAIT_DROP} state_t;

    state_t               state_q, state_d;
    logic [31:2]          addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 we_q, we_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [0:1023]        l2_block_q, l2_block_d;
    logic                 mem_ren_q, mem_ren_d, mem_wen_q, mem_wen_d;
    logic [31:0]          mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [SETS-1:0]      valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q [SETS];
    logic [0:1023]        data_q [SETS];
    logic [SETS_LOG2-1:0] idx;
    logic [TAG_W-1:0]     tag;
    logic                 hit, line_we, go_rd, go_wr;
    logic [0:1023]        line_d;
    logic                 unused_lsbs;

    function automatic logic [0:1023] merge(input logic [0:1023] line, input logic [4:0] w, input logic [31:0] word);
        merge = line;
        merge[{w, 5'b0} +: 32] = word;
    endfunction

    assign idx         = addr_q[6+SETS_LOG2:7];
    assign tag         = addr_q[31:7+SETS_LOG2];
    assign hit         = valid_q[idx] && tag_q[idx] == tag;
    assign unused_lsbs = ^L3_addr[1:0];
    assign L3_stall    = L3_renable && state_q != DONE;
    assign L2_block    = l2_block_q;
    assign mem_addr    = mem_addr_q;
    assign mem_renable = mem_ren_q;
    assign mem_wenable = mem_wen_q;
    assign mem_wdata   = mem_wdata_q;

    // next-state, line update and memory-port strobes; go_rd/go_wr launch a memory request
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        we_d = we_q;
        cnt_d = cnt_q;
        l2_block_d = l2_block_q;
        mem_ren_d = mem_ren_q;
        mem_wen_d = mem_wen_q;
        mem_addr_d = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        valid_d = valid_q;
        line_we = 1'b0;
        line_d = data_q[idx];
        go_rd = 1'b0;
        go_wr = 1'b0;
        case (state_q)
            IDLE: if (L3_renable) begin
                state_d = LOOKUP;
                addr_d = L3_addr[31:2];
                wdata_d = L3_wdata;
                we_d = L3_wenable;
                cnt_d = '0;
            end
            LOOKUP: if (cnt_q != CNT_W'(HIT_LATENCY)) cnt_d = cnt_q + 1'b1;
                else if (hit && !we_q) begin
                    l2_block_d = data_q[idx];
                    state_d = DONE;
                end else if (hit) begin
                    line_we = 1'b1;
                    line_d = merge(data_q[idx], addr_q[6:2], wdata_q);
                    go_wr = 1'b1;
                end
`ifdef L3_WRITE_ALLOCATE_EN
                else go_rd = 1'b1;
`else
                else if (!we_q) go_rd = 1'b1;
                else go_wr = 1'b1;
`endif
            MEM_RD: if (mem_ready) begin
                mem_ren_d = 1'b0;
                line_we = 1'b1;
                valid_d[idx] = 1'b1;
                line_d = we_q ? merge(mem_rdata, addr_q[6:2], wdata_q) : mem_rdata;
                l2_block_d = we_q ? l2_block_q : mem_rdata;
                state_d = DONE;
                go_wr = we_q;
            end
            MEM_WR: if (mem_ready) begin
                mem_wen_d = 1'b0;
                state_d = DONE;
            end
            DONE: state_d = WAIT_DROP;
            WAIT_DROP: if (!L3_renable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (go_rd) begin
            state_d = MEM_RD;
            mem_ren_d = 1'b1;
            mem_addr_d = {addr_q[31:7], 7'b0};
        end
        if (go_wr) begin
            state_d = MEM_WR;
            mem_wen_d = 1'b1;
            mem_addr_d = {addr_q[31:2], 2'b0};
            mem_wdata_d = wdata_q;
        end
    end

    // control registers; reset invalidates every line in one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q <= '0;
            wdata_q <= '0;
            we_q <= 1'b0;
            cnt_q <= '0;
            l2_block_q <= '0;
            mem_ren_q <= 1'b0;
            mem_wen_q <= 1'b0;
            mem_addr_q <= '0;
            mem_wdata_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            we_q <= we_d;
            cnt_q <= cnt_d;
            l2_block_q <= l2_block_d;
            mem_ren_q <= mem_ren_d;
            mem_wen_q <= mem_wen_d;
            mem_addr_q <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            valid_q <= valid_d;
        end
    end

    // tag/data arrays; a fill racing a reset is dropped
    always_ff @(posedge clk) begin
        if (line_we && !reset) begin
            data_q[idx] <= line_d;
            tag_q[idx] <= tag;
        end
    end
endmodule

// File: tb/tb_l3_cache.sv
// tb_l3_cache: directed plus random requests against a memory responder and a line-level cache model
`define CHK(name, obs, want) begin checks++; assert ((obs) === (want)) else begin failures++; $error("FAIL %s obs=%0h exp=%0h", name, (obs), (want)); end end

module tb_l3_cache;
    localparam int SL   = 8;
    localparam int HL   = 10;
    localparam int SETS = 1 << SL;

    logic          clk = 0;
    logic          reset;
    logic [31:0]   L3_addr, L3_wdata;
    logic          L3_renable, L3_wenable, L3_stall;
    logic [0:1023] L2_block, mem_rdata;
    logic [31:0]   mem_addr, mem_wdata;
    logic          mem_renable, mem_wenable, mem_ready;

    int checks = 0, failures = 0;
    int rd_cnt = 0, wr_cnt = 0, both_hi = 0, rsp_delay = 0;
    int stray_req = 0, stray_done = 0;
    logic [31:0] rd_addr, wr_addr, wr_data;
    logic [31:0] mem_words [logic [29:0]];
    logic [31:0] ref_words [logic [29:0]];
    int ref_tag [int];
    logic [0:1023] exp_l2 = '0;

    l3_cache #(.SETS_LOG2(SL), .HIT_LATENCY(HL)) dut (
        .clk(clk), .reset(reset), .L3_addr(L3_addr), .L3_wdata(L3_wdata),
        .L3_renable(L3_renable), .L3_wenable(L3_wenable), .L3_stall(L3_stall),
        .L2_block(L2_block), .mem_addr(mem_addr), .mem_renable(mem_renable),
        .mem_wenable(mem_wenable), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [29:0] wa);
        return ({wa, 2'b00} * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [0:1023] line_of(input bit use_ref, input logic [31:0] la);
        logic [0:1023] l;
        logic [29:0] wa;
        for (int k = 0; k < 32; k++) begin
            wa = la[31:2] + 30'(k);
            if (use_ref) l[k*32 +: 32] = ref_words.exists(wa) ? ref_words[wa] : init_word(wa);
            else l[k*32 +: 32] = mem_words.exists(wa) ? mem_words[wa] : init_word(wa);
        end
        return l;
    endfunction

    // memory: answers each strobe after rsp_delay cycles; can inject a stray ready pulse
    initial begin
        int age = 0;
        mem_ready = 0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ready = 0;
            if (mem_renable && mem_wenable) both_hi++;
            if (!mem_renable && !mem_wenable) age = 0;
            else if (age < rsp_delay) age++;
            else begin
                age = 0;
                mem_ready = 1;
                if (mem_renable) begin
                    rd_cnt++;
                    rd_addr = mem_addr;
                    mem_rdata = line_of(0, mem_addr);
                end else begin
                    wr_cnt++;
                    wr_addr = mem_addr;
                    wr_data = mem_wdata;
                    mem_words[mem_addr[31:2]] = mem_wdata;
                end
            end
            if (stray_req != stray_done) begin
                stray_done = stray_req;
                mem_ready = 1;
                mem_rdata = '1;
            end
        end
    end

    task automatic chk_blk(input string name, input logic [0:1023] want);
        int k = 0;
        checks++;
        assert (L2_block === want) else begin
            failures++;
            while (k < 31 && L2_block[k*32 +: 32] === want[k*32 +: 32]) k++;
            $error("FAIL %s word%0d obs=%h exp=%h", name, k, L2_block[k*32 +: 32], want[k*32 +: 32]);
        end
    endtask

    task automatic finish_req(input int exp_lat, input int exp_rd, input int exp_wr,
                              input logic [31:0] exp_ra, input logic [31:0] exp_wa,
                              input logic [31:0] exp_wd, input string name);
        int n = 0;
        int rd0 = rd_cnt;
        int wr0 = wr_cnt;
        @(posedge clk);
        while (n < 500) begin
            @(posedge clk);
            n++;
            #1;
            if (!L3_stall) break;
        end
        `CHK({name, " lat"}, n, exp_lat)
        `CHK({name, " rd_cnt"}, rd_cnt - rd0, exp_rd)
        `CHK({name, " wr_cnt"}, wr_cnt - wr0, exp_wr)
        if (exp_rd > 0) `CHK({name, " rd_addr"}, rd_addr, exp_ra)
        if (exp_wr > 0) begin
            `CHK({name, " wr_addr"}, wr_addr, exp_wa)
            `CHK({name, " wr_data"}, wr_data, exp_wd)
        end
        chk_blk({name, " block"}, exp_l2);
        `CHK({name, " strobes"}, {mem_renable, mem_wenable}, 2'b00)
        @(posedge clk);
        #1;
        `CHK({name, " stall_after"}, L3_stall, 1'b1)
        L3_renable = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [31:0] a, input logic w, input logic [31:0] d, input string name);
        int idx, tg, nrd, nwr;
        bit hit;
        idx = int'((a >> 7) & (SETS - 1));
        tg = int'(a >> (7 + SL));
        hit = ref_tag.exists(idx) && ref_tag[idx] == tg;
        nrd = 0;
        nwr = 0;
        if (!w) begin
            if (!hit) begin
                nrd = 1;
                ref_tag[idx] = tg;
            end
            exp_l2 = line_of(1, {a[31:7], 7'b0});
        end else begin
            nwr = 1;
            ref_words[a[31:2]] = d;
`ifdef L3_WRITE_ALLOCATE_EN
            if (!hit) begin
                nrd = 1;
                ref_tag[idx] = tg;
            end
`endif
        end
        L3_addr = a;
        L3_wdata = d;
        L3_wenable = w;
        L3_renable = 1;
        finish_req(HL + 1 + (nrd + nwr) * (rsp_delay + 1), nrd, nwr, {a[31:7], 7'b0}, {a[31:2], 2'b00}, d, name);
    endtask

    initial begin
        logic [31:0] a;
        int n;
        reset = 1;
        L3_addr = 0;
        L3_wdata = 0;
        L3_renable = 0;
        L3_wenable = 0;
        repeat (3) @(posedge clk);
        #1;
        `CHK("rst stall_lo", L3_stall, 1'b0)
        `CHK("rst mem_ren", mem_renable, 1'b0)
        `CHK("rst mem_wen", mem_wenable, 1'b0)
        `CHK("rst mem_addr", mem_addr, 32'h0)
        `CHK("rst mem_wdata", mem_wdata, 32'h0)
        chk_blk("rst block", '0);
        L3_renable = 1;
        #1;
        `CHK("rst stall_hi", L3_stall, 1'b1)
        L3_renable = 0;
        @(posedge clk);
        #1;
        reset = 0;

        rsp_delay = 2;
        step(32'h0000_1000, 0, 0, "rd_miss");
        step(32'h0000_1040, 0, 0, "rd_hit");
        step(32'h0000_1008, 1, 32'hDEADBEEF, "wr_hit");
        step(32'h0000_1000, 0, 0, "rd_after_wr");
        `CHK("merged word", L2_block[64:95], 32'hDEADBEEF)
        rsp_delay = 0;
        step(32'h0002_0000, 1, 32'hCAFEF00D, "wr_miss");
        step(32'h0002_0000, 0, 0, "rd_after_wr_miss");
        rsp_delay = 1;
        step(32'h0000_1000, 0, 0, "conflict_a");
        step(32'h0000_1000 + (1 << (7 + SL)), 0, 0, "conflict_b");
        step(32'h0000_1000, 0, 0, "conflict_a_again");

        // reset while the fill is outstanding, with the request still held
        rsp_delay = 6;
        L3_addr = 32'h0000_3000;
        L3_wenable = 0;
        L3_renable = 1;
        n = 0;
        while (!mem_renable && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        `CHK("mid_rst strobe_up", mem_renable, 1'b1)
        @(posedge clk);
        #1;
        reset = 1;
        @(posedge clk);
        #1;
        `CHK("mid_rst strobe_drop", mem_renable, 1'b0)
        chk_blk("mid_rst block", '0);
        reset = 0;
        ref_tag.delete();
        ref_tag[int'((32'h3000 >> 7) & (SETS - 1))] = int'(32'h3000 >> (7 + SL));
        exp_l2 = line_of(1, 32'h0000_3000);
        stray_req++;
        finish_req(HL + 1 + 7, 1, 0, 32'h0000_3000, 0, 0, "mid_rst refill");
        rsp_delay = 0;
        step(32'h0000_1000, 0, 0, "after_rst_invalid");

        for (int i = 0; i < 40; i++) begin
            a = (32'($urandom_range(0, 1)) << (7 + SL)) | ((32'h20 + 32'($urandom_range(0, 1))) << 7) | ($urandom & 32'h7F);
            rsp_delay = $urandom_range(0, 3);
            step(a, 1'($urandom_range(0, 1)), $urandom, $sformatf("rnd%0d", i));
        end
        `CHK("never_both_strobes", both_hi, 0)

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
